// File: rtl/shift_iter_if.sv
// rtl/shift_iter_if.sv - start/done handshake and operand/result bundle for shift_iter
interface shift_iter_if;
    logic        start;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic [1:0]  Op;
    logic [15:0] Out;
    logic        busy;
    logic        done;

    modport master (output start, In, Cnt, Op, input Out, busy, done);
    modport slave  (input start, In, Cnt, Op, output Out, busy, done);
endinterface

// File: rtl/shift_iter.sv
// rtl/shift_iter.sv - iterative 16-bit shift/rotate unit, one position per clock
// Optional SHIFT_ITER_DUAL_EN: two positions per clock while at least two remain.
module shift_iter (
    input  logic         clk,
    input  logic         rst,
    shift_iter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state;
    logic [3:0]  rem;
    logic [1:0]  op_r;

    function automatic logic [15:0] step(input logic [15:0] v, input logic [1:0] op);
        case (op)
            2'b00:   step = {v[14:0], v[15]};
            2'b01:   step = {v[14:0], 1'b0};
            2'b10:   step = {v[0], v[15:1]};
            default: step = {1'b0, v[15:1]};
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bus.Out  <= 16'h0000;
            rem      <= 4'd0;
            op_r     <= 2'b00;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                    // DONE accepts a start like IDLE so operations can run back to back
                    if (bus.start) begin
                        bus.Out <= bus.In;
                        op_r    <= bus.Op;
                        rem     <= bus.Cnt;
                        if (bus.Cnt == 4'd0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state    <= SHIFT;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
`ifdef SHIFT_ITER_DUAL_EN
                    if (rem >= 4'd2) begin
                        bus.Out <= step(step(bus.Out, op_r), op_r);
                        rem     <= rem - 4'd2;
                    end else begin
                        bus.Out <= step(bus.Out, op_r);
                        rem     <= rem - 4'd1;
                    end
                    if (rem <= 4'd2) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
`else
                    bus.Out <= step(bus.Out, op_r);
                    rem     <= rem - 4'd1;
                    if (rem == 4'd1) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
`endif
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule
